// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings, fetch width
// and the per-request tag carried from request to response.
package ifu_fetch_pkg;

  localparam int FETCH_W = 64;
  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    FENCE = 2'd2
  } ifu_state_e;

  // Doubleword base of an in-flight request plus whether its low word is skipped.
  typedef struct packed {
    logic [28:0] base;
    logic        skip;
  } fetch_tag_t;

endpackage

// File: rtl/ifu_iqueue.sv
// Instruction queue: circular buffer of PC-tagged 32-bit words with up to two
// pushes and one pop per cycle; flush empties it in a single cycle.
module ifu_iqueue
  import ifu_fetch_pkg::*;
#(
  parameter int QD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [1:0]           push_cnt,
  input  logic [INSTR_W-1:0]   push_data0,
  input  logic [31:0]          push_pc0,
  input  logic [INSTR_W-1:0]   push_data1,
  input  logic [31:0]          push_pc1,
  input  logic                 pop,
  output logic [INSTR_W-1:0]   head_data,
  output logic [31:0]          head_pc,
  output logic [$clog2(QD):0]  count
);

  localparam int AW = $clog2(QD);

  logic [INSTR_W-1:0] data_mem_r [QD];
  logic [31:0]        pc_mem_r   [QD];
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [AW:0]        count_r;
  logic [AW-1:0]      wr_ptr1_s;
  logic               pop_s;

  assign pop_s     = pop && (count_r != '0);
  assign wr_ptr1_s = wr_ptr_r + AW'(1);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      wr_ptr_r <= wr_ptr_r + AW'(push_cnt);
      rd_ptr_r <= rd_ptr_r + AW'(pop_s);
      count_r  <= count_r + (AW+1)'(push_cnt) - (AW+1)'(pop_s);
    end
  end

  // Entry storage; the second push always lands one slot after the first.
  always_ff @(posedge clk) begin
    if (!flush && (push_cnt != 2'd0)) begin
      data_mem_r[wr_ptr_r] <= push_data0;
      pc_mem_r[wr_ptr_r]   <= push_pc0;
    end
    if (!flush && (push_cnt == 2'd2)) begin
      data_mem_r[wr_ptr1_s] <= push_data1;
      pc_mem_r[wr_ptr1_s]   <= push_pc1;
    end
  end

  assign head_data = data_mem_r[rd_ptr_r];
  assign head_pc   = pc_mem_r[rd_ptr_r];
  assign count     = count_r;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: issues 8-byte fetches, splits responses into a PC-tagged
// queue, handles redirects. Optional fence.i sequencing is enabled by IFU_FENCEI_EN.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          QD       = 8
) (
  input  logic               CLK,
  input  logic               RST,
  output logic               ifu_req_valid,
  input  logic               ifu_req_ready,
  output logic [31:0]        ifu_addr_req,
  input  logic [FETCH_W-1:0] ifu_data_rsp,
  input  logic               ifu_rsp_valid,
  output logic               ifu_rsp_ready,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               fencei_valid,
  output logic               il1_fence,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [31:0]        instr_pc
);

  localparam int CW = $clog2(QD) + 1;

  ifu_state_e         state_r, state_nx_s;
  logic [31:2]        fetch_pc_r;
  logic [1:0]         outst_r, outst_nx_s, drop_r;
  fetch_tag_t         tag_r [2];
  fetch_tag_t         new_tag_s;
  logic [1:0]         tag_cnt_r;
  logic [CW-1:0]      q_count_s, free_s;
  logic [2:0]         need_s;
  logic               fence_take_s, flush_s, req_valid_s, req_fire_s;
  logic               rsp_fire_s, rsp_live_s, pop_s;
  logic [1:0]         push_cnt_s;
  logic [INSTR_W-1:0] push_data0_s, push_data1_s;
  logic [31:0]        push_pc0_s, push_pc1_s;
  logic               unused_pc_bits_s;

`ifdef IFU_FENCEI_EN
  assign fence_take_s = !RST && (state_r == FETCH) && fencei_valid;
  assign il1_fence    = !RST && (state_r == FENCE);
`else
  logic unused_fencei_s;
  assign unused_fencei_s = fencei_valid;
  assign fence_take_s    = 1'b0;
  assign il1_fence       = 1'b0;
`endif

  assign unused_pc_bits_s = ^redirect_pc[1:0];
  assign flush_s    = !RST && (redirect_valid || fence_take_s);
  assign free_s     = CW'(QD) - q_count_s;
  // Room for every word of every request already in flight plus the new one.
  assign need_s     = {outst_r, 1'b0} + 3'd2;
  assign req_valid_s = !RST && (state_r == FETCH) && !redirect_valid && !fence_take_s &&
                       (outst_r < 2'd2) && (drop_r == 2'd0) && (free_s >= CW'(need_s));
  assign req_fire_s = req_valid_s && ifu_req_ready;
  // Responses with nothing outstanding (e.g. just after reset) are ignored.
  assign rsp_fire_s = !RST && ifu_rsp_valid && (outst_r != 2'd0);
  assign rsp_live_s = rsp_fire_s && (drop_r == 2'd0) && !flush_s;
  assign new_tag_s  = '{base: fetch_pc_r[31:3], skip: fetch_pc_r[2]};

  assign ifu_req_valid = req_valid_s;
  assign ifu_addr_req  = {fetch_pc_r[31:3], 3'b000};
  assign ifu_rsp_ready = 1'b1;
  assign instr_valid   = !RST && (q_count_s != '0);
  assign pop_s         = instr_valid && instr_ready;

  // Net outstanding-request count for this cycle's handshakes.
  always_comb begin
    outst_nx_s = outst_r;
    if (req_fire_s && !rsp_fire_s) begin
      outst_nx_s = outst_r + 2'd1;
    end else if (!req_fire_s && rsp_fire_s) begin
      outst_nx_s = outst_r - 2'd1;
    end else begin
      outst_nx_s = outst_r;
    end
  end

  // Next-state logic for the fetch / fence sequencer.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      FETCH: begin
        if (fence_take_s) state_nx_s = DRAIN;
        else              state_nx_s = FETCH;
      end
      DRAIN: begin
        if (outst_r == 2'd0) state_nx_s = FENCE;
        else                 state_nx_s = DRAIN;
      end
      FENCE:   state_nx_s = FETCH;
      default: state_nx_s = FETCH;
    endcase
  end

  // Control registers: state, fetch PC, outstanding and drop counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r    <= FETCH;
      fetch_pc_r <= RESET_PC[31:2];
      outst_r    <= 2'd0;
      drop_r     <= 2'd0;
    end else begin
      state_r <= state_nx_s;
      outst_r <= outst_nx_s;
      if (flush_s) begin
        fetch_pc_r <= redirect_pc[31:2];
      end else if (req_fire_s) begin
        fetch_pc_r <= {fetch_pc_r[31:3] + 29'd1, 1'b0};
      end
      if (flush_s) begin
        drop_r <= outst_nx_s;
      end else if (rsp_fire_s && (drop_r != 2'd0)) begin
        drop_r <= drop_r - 2'd1;
      end
    end
  end

  // In-order tags of live requests; responses always return in request order.
  always_ff @(posedge CLK) begin
    if (RST || flush_s) begin
      tag_cnt_r <= 2'd0;
    end else begin
      case ({req_fire_s, rsp_live_s})
        2'b10: begin
          tag_r[tag_cnt_r[0]] <= new_tag_s;
          tag_cnt_r           <= tag_cnt_r + 2'd1;
        end
        2'b01: begin
          tag_r[0]  <= tag_r[1];
          tag_cnt_r <= tag_cnt_r - 2'd1;
        end
        2'b11: begin
          if (tag_cnt_r == 2'd1) begin
            tag_r[0] <= new_tag_s;
          end else begin
            tag_r[0] <= tag_r[1];
            tag_r[1] <= new_tag_s;
          end
        end
        default: tag_cnt_r <= tag_cnt_r;
      endcase
    end
  end

  // Split a live response into one or two queue entries.
  always_comb begin
    push_cnt_s   = 2'd0;
    push_data0_s = ifu_data_rsp[31:0];
    push_pc0_s   = {tag_r[0].base, 3'b000};
    push_data1_s = ifu_data_rsp[63:32];
    push_pc1_s   = {tag_r[0].base, 3'b100};
    if (rsp_live_s) begin
      if (tag_r[0].skip) begin
        push_cnt_s   = 2'd1;
        push_data0_s = ifu_data_rsp[63:32];
        push_pc0_s   = {tag_r[0].base, 3'b100};
      end else begin
        push_cnt_s = 2'd2;
      end
    end else begin
      push_cnt_s = 2'd0;
    end
  end

  ifu_iqueue #(.QD(QD)) u_iqueue (
    .clk        (CLK),
    .rst        (RST),
    .flush      (flush_s),
    .push_cnt   (push_cnt_s),
    .push_data0 (push_data0_s),
    .push_pc0   (push_pc0_s),
    .push_data1 (push_data1_s),
    .push_pc1   (push_pc1_s),
    .pop        (pop_s),
    .head_data  (instr_data),
    .head_pc    (instr_pc),
    .count      (q_count_s)
  );

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: randomized I-cache and decode models, with the
// expected instruction stream derived from the fetch rules (PC += 4 from each restart).
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk, rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
  logic [31:0] ifu_addr_req;
  logic [63:0] ifu_data_rsp;
  logic        redirect_valid, fencei_valid, il1_fence;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr_data, instr_pc;

  ifu_fetch #(.RESET_PC(RESET_PC), .QD(8)) dut (
    .CLK(clk), .RST(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_addr_req(ifu_addr_req), .ifu_data_rsp(ifu_data_rsp),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fencei_valid(fencei_valid), .il1_fence(il1_fence),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t       pend[$];
  logic [31:0] hs_log[$];
  int          checks = 0, failures = 0;
  int          cyc = 0, outst = 0, stale = 0, hs_count = 0, pops = 0, il1_count = 0;
  int          lat_min = 1, lat_max = 1, rr_pct = 100, ir_pct = 100;
  logic [31:0] exp_pc, exp_fetch, last_hs_addr, last_pop_pc;
  bit          rsp_now, junk_rsp;

  // Contents of instruction memory as seen through the I-cache.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h5A5A_C3C3) + {a[15:0], a[31:16]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive cache/decode side, observe handshakes, update the model.
  task automatic tick();
    logic req_hs, pop_hs, flush;
    logic [31:0] a;
    rsp_now = 1'b0;
    if (junk_rsp) begin
      ifu_rsp_valid = 1'b1;
      ifu_data_rsp  = 64'hDEAD_BEEF_0BAD_F00D;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      ifu_rsp_valid = 1'b1;
      ifu_data_rsp  = {mem_word(pend[0].addr + 32'd4), mem_word(pend[0].addr)};
      rsp_now       = 1'b1;
    end else begin
      ifu_rsp_valid = 1'b0;
      ifu_data_rsp  = {$urandom, $urandom};
    end
    ifu_req_ready = ($urandom_range(99) < rr_pct);
    instr_ready   = ($urandom_range(99) < ir_pct);
    #1;
    req_hs = !rst && ifu_req_valid && ifu_req_ready;
    pop_hs = !rst && instr_valid && instr_ready;
    a      = ifu_addr_req;
    if (!rst && il1_fence) il1_count++;
    if (pop_hs) begin
      check("pop_pc", instr_pc, exp_pc);
      check("pop_data", instr_data, mem_word(exp_pc));
      last_pop_pc = instr_pc;
      exp_pc += 32'd4;
      pops++;
    end
    if (req_hs) begin
      check("req_addr", a, exp_fetch);
      check("req_while_dropping", stale, 0);
      check("req_outstanding_lt2", {31'd0, outst < 2}, 32'd1);
      exp_fetch += 32'd8;
      hs_count++;
      last_hs_addr = a;
      hs_log.push_back(a);
    end
    @(posedge clk);
    if (!rst) begin
      if (rsp_now) begin
        void'(pend.pop_front());
        outst--;
        if (stale > 0) stale--;
      end
      if (req_hs) begin
        pend.push_back('{a, cyc + $urandom_range(lat_max, lat_min)});
        outst++;
      end
      flush = redirect_valid;
`ifdef IFU_FENCEI_EN
      flush = flush || fencei_valid;
`endif
      if (flush) begin
        stale     = outst;
        exp_pc    = redirect_pc & ~32'd3;
        exp_fetch = redirect_pc & ~32'd7;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    fencei_valid   = 1'b0;
    tick();
    tick();
    check("rst_req_valid", {31'd0, ifu_req_valid}, 32'd0);
    check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_il1_fence", {31'd0, il1_fence}, 32'd0);
    check("rst_rsp_ready", {31'd0, ifu_rsp_ready}, 32'd1);
    pend.delete();
    outst = 0; stale = 0;
    exp_pc = RESET_PC; exp_fetch = RESET_PC;
    rst = 1'b0;
    junk_rsp = 1'b1;
    tick();
    junk_rsp = 1'b0;
  endtask

  initial begin
    int hs0, pops0;
    rst = 1'b1; ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_data_rsp = '0;
    redirect_valid = 1'b0; redirect_pc = '0; fencei_valid = 1'b0; instr_ready = 1'b0;
    junk_rsp = 1'b0;
    @(negedge clk);

    // Stalled decode: queue of 8 fills with exactly 4 requests.
    ir_pct = 0; hs_count = 0;
    do_reset();
    repeat (20) tick();
    check("stall_req_count", hs_count, 4);
    check("stall_req_valid", {31'd0, ifu_req_valid}, 32'd0);
    ir_pct = 100; tick(); ir_pct = 0;
    check("one_pop_req_valid", {31'd0, ifu_req_valid}, 32'd0);
    ir_pct = 100; tick(); ir_pct = 0;
    check("two_pop_req_valid", {31'd0, ifu_req_valid}, 32'd1);

    // Sequential fetch with 1-cycle hits from reset.
    ir_pct = 100; pops = 0;
    do_reset();
    repeat (30) tick();
    check("seq_pops_min", {31'd0, pops >= 16}, 32'd1);

    // Redirect with two requests in flight.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && outst != 2; i++) tick();
    check("setup_two_outstanding", outst, 2);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0104;
    tick();
    redirect_valid = 1'b0;
    hs0 = hs_count; pops0 = pops;
    for (int i = 0; i < 30 && hs_count == hs0; i++) tick();
    check("rdr_next_req", last_hs_addr, 32'h8000_0100);
    for (int i = 0; i < 30 && pops == pops0; i++) tick();
    check("rdr_first_pc", last_pop_pc, 32'h8000_0104);

    // Redirect coinciding with a returning response.
    lat_min = 1; lat_max = 1;
    repeat (10) tick();
    for (int i = 0; i < 10; i++) begin
      if (pend.size() > 0 && pend[0].due <= cyc) break;
      tick();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0400;
    tick();
    redirect_valid = 1'b0;
    check("rdr_rsp_same_cycle", {31'd0, rsp_now}, 32'd1);
    check("rdr_rsp_queue_empty", {31'd0, instr_valid}, 32'd0);
    pops0 = pops;
    for (int i = 0; i < 30 && pops == pops0; i++) tick();
    check("rdr_rsp_first_pc", last_pop_pc, 32'h8000_0400);

    // Address wrap at the top of the 32-bit space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    hs_log.delete();
    for (int i = 0; i < 40 && hs_log.size() < 2; i++) tick();
    check("wrap_req0", (hs_log.size() > 0) ? hs_log[0] : 32'hXXXX_XXXX, 32'hFFFF_FFF8);
    check("wrap_req1", (hs_log.size() > 1) ? hs_log[1] : 32'hXXXX_XXXX, 32'h0000_0000);
    repeat (6) tick();

    // fence.i: drain, single invalidate pulse, resume at redirect_pc.
    il1_count = 0;
`ifdef IFU_FENCEI_EN
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 30 && outst != 1; i++) tick();
    check("fence_setup_outstanding", outst, 1);
    fencei_valid = 1'b1; redirect_pc = 32'h8000_0200;
    tick();
    fencei_valid = 1'b0;
    hs0 = hs_count;
    for (int i = 0; i < 40 && hs_count == hs0; i++) tick();
    check("fence_pulse_count", il1_count, 1);
    check("fence_resume_addr", last_hs_addr, 32'h8000_0200);
    repeat (4) tick();
    check("fence_pulse_once", il1_count, 1);
`else
    fencei_valid = 1'b1; redirect_pc = 32'h8000_0800;
    tick();
    fencei_valid = 1'b0;
    hs0 = hs_count;
    repeat (12) tick();
    check("fencei_ignored_il1", il1_count, 0);
    check("fencei_ignored_fetch", {31'd0, hs_count > hs0}, 32'd1);
`endif

    // Randomized traffic with occasional redirects.
    lat_min = 1; lat_max = 3; rr_pct = 70; ir_pct = 60; pops0 = pops;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99) < 3) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom;
      end
      tick();
      redirect_valid = 1'b0;
    end
    check("random_pops_min", {31'd0, (pops - pops0) > 200}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
